// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares the single read/write port of the 32x256 SRAM macro between two
//   requesters (0 = core load/store, 1 = loader/debug DMA). Byte-addressed
//   byte/half/word accesses become a word address, a write mask and lane-
//   replicated write data. Read data returns aligned and sign/zero-extended
//   in the cycle after accept. Misaligned or illegal-size accesses are
//   accepted but answered with an error and never touch the SRAM.
//
// Ports
//   clk, rst_n      clock (also the macro clock), async active-low reset
//   req_valid/ready per-requester handshake; ready is the combinational grant
//   req_we          1 = write, 0 = read
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    read extension: 1 = zero, 0 = sign
//   req_addr        byte address (ADDR_WIDTH+2 bits)
//   req_wdata       right-justified write data
//   rsp_valid/err   one-cycle response pulse per accepted request, by id
//   rsp_rdata       shared read data, 0 for writes and errors
//   sram_*          macro port 0 (csb0, web0, wmask0, addr0, din0, dout0)
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [1:0][1:0]             req_size,
    input  logic [1:0]                  req_unsigned,
    input  logic [1:0][ADDR_WIDTH+1:0]  req_addr,
    input  logic [1:0][31:0]            req_wdata,
    output logic [1:0]                  rsp_valid,
    output logic [1:0]                  rsp_err,
    output logic [31:0]                 rsp_rdata,
    output logic                        sram_csb,
    output logic                        sram_web,
    output logic [3:0]                  sram_wmask,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic [31:0]                 sram_din,
    input  logic [31:0]                 sram_dout
);

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } size_e;

    logic                  rr_ptr;
    logic                  any_valid;
    logic                  both_valid;
    logic                  gnt_id;
    logic                  accept;

    logic                  sel_we;
    logic                  sel_uns;
    size_e                 sel_size;
    logic [ADDR_WIDTH+1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic [1:0]            sel_off;
    logic                  sel_err;

    logic                  rsp_pend_q;
    logic                  rsp_id_q;
    logic                  rsp_we_q;
    logic                  rsp_err_q;
    size_e                 rsp_size_q;
    logic                  rsp_uns_q;
    logic [1:0]            rsp_off_q;
    logic [31:0]           lane_data;

    // Grant: a lone requester always wins; on contention the round-robin
    // pointer (or requester 0 in fixed-priority mode) decides. Gating with
    // rst_n keeps ready low and the SRAM idle the moment reset asserts.
    always_comb begin
        any_valid  = |req_valid;
        both_valid = &req_valid;
        if (both_valid) begin
            gnt_id = FIXED_PRIO ? 1'b0 : rr_ptr;
        end else begin
            gnt_id = req_valid[1];
        end
        accept    = any_valid & rst_n;
        req_ready = 2'b00;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Mux the granted request and classify alignment.
    always_comb begin
        sel_we    = req_we[gnt_id];
        sel_uns   = req_unsigned[gnt_id];
        sel_size  = size_e'(req_size[gnt_id]);
        sel_addr  = req_addr[gnt_id];
        sel_wdata = req_wdata[gnt_id];
        sel_off   = sel_addr[1:0];
        case (sel_size)
            SIZE_BYTE: sel_err = 1'b0;
            SIZE_HALF: sel_err = sel_off[0];
            SIZE_WORD: sel_err = |sel_off;
            default:   sel_err = 1'b1;
        endcase
    end

    // Macro drive for the accept cycle; sub-word writes replicate the data
    // into every lane so the mask alone selects the target bytes.
    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = 4'b0000;
        sram_din   = 32'h0;
        sram_addr  = sel_addr[ADDR_WIDTH+1:2];
        if (accept && !sel_err) begin
            sram_csb = 1'b0;
            sram_web = ~sel_we;
            if (sel_we) begin
                case (sel_size)
                    SIZE_BYTE: begin
                        sram_wmask = 4'b0001 << sel_off;
                        sram_din   = {4{sel_wdata[7:0]}};
                    end
                    SIZE_HALF: begin
                        sram_wmask = sel_off[1] ? 4'b1100 : 4'b0011;
                        sram_din   = {2{sel_wdata[15:0]}};
                    end
                    default: begin
                        sram_wmask = 4'b1111;
                        sram_din   = sel_wdata;
                    end
                endcase
            end
        end
    end

    // Round-robin pointer only moves after a contested grant, handing the
    // next contest to the side that just lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (accept && both_valid) begin
            rr_ptr <= ~gnt_id;
        end
    end

    // Single response stage: remembers what is needed to format the reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_we_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_size_q <= SIZE_BYTE;
            rsp_uns_q  <= 1'b0;
            rsp_off_q  <= 2'b00;
        end else begin
            rsp_pend_q <= accept;
            if (accept) begin
                rsp_id_q   <= gnt_id;
                rsp_we_q   <= sel_we;
                rsp_err_q  <= sel_err;
                rsp_size_q <= sel_size;
                rsp_uns_q  <= sel_uns;
                rsp_off_q  <= sel_off;
            end
        end
    end

    // Read data is formatted combinationally from dout0, which the macro
    // updates mid-cycle, so no extra register stage is needed.
    always_comb begin
        rsp_valid = 2'b00;
        rsp_err   = 2'b00;
        rsp_rdata = 32'h0;
        lane_data = sram_dout >> {rsp_off_q, 3'b000};
        if (rsp_pend_q) begin
            rsp_valid[rsp_id_q] = 1'b1;
            rsp_err[rsp_id_q]   = rsp_err_q;
            if (!rsp_we_q && !rsp_err_q) begin
                case (rsp_size_q)
                    SIZE_BYTE: rsp_rdata = {{24{~rsp_uns_q & lane_data[7]}}, lane_data[7:0]};
                    SIZE_HALF: rsp_rdata = {{16{~rsp_uns_q & lane_data[15]}}, lane_data[15:0]};
                    default:   rsp_rdata = lane_data;
                endcase
            end
        end
    end

endmodule
